ovi_issue_arbiter: RTL
======================

# ovi_issue_arbiter

Shares the single OVI issue port between NREQ scalar-side requesters, such as harts or decode lanes. It owns issue-credit accounting and sb_id allocation toward the VPU, keeps an in-flight ownership table, and routes each VPU completion back to the requester that issued it. It sits between the core-side issue buses and the OVI bridge, and supports a drain/flush sequence before vector CSR changes.

## Interface
- NREQ, default 2: number of requesters, 2..4.
- CREDITS, default 4: issue credits the VPU grants at reset.
- SBID_W, default 5: sb_id width; the ownership table holds 2^SBID_W entries.
- CLK  in  1  clock, all state changes on rising edge.
- RST_N  in  1  reset; asynchronous assert, active-low, synchronous release expected from top.
- REQ_VALID  in  NREQ  requester i holds an instruction.
- REQ_INSTR  in  NREQ*32  instruction of requester i, bits [32i+31:32i].
- REQ_GRANT  out  NREQ  one-hot accept; requester drops or advances its instruction after the edge.
- ISSUE_VALID  out  1  issue to VPU.
- ISSUE_INSTR  out  32  issued instruction.
- ISSUE_SBID  out  SBID_W  sb_id of issued instruction.
- ISSUE_CREDIT  in  1  VPU returns one credit.
- COMPL_VALID  in  1  VPU completion.
- COMPL_SBID  in  SBID_W  sb_id being completed.
- COMPL_ROUTE  out  NREQ  one-hot completion forwarded to the owner.
- FLUSH_REQ  in  1  level; stop granting and drain.
- FLUSH_DONE  out  1  one-cycle pulse when drain completes.
- CREDIT_CNT  out  clog2(CREDITS+1)  current credits.
- ERR  out  1  sticky protocol error; cleared only by reset.

## Operation
- State machine RUN / DRAIN / DONE. Reset state is RUN.
- RUN to DRAIN when FLUSH_REQ=1.
- DRAIN to DONE when the in-flight count is 0 and no registered issue is pending. The transition takes effect at the next edge after those conditions hold.
- DONE: FLUSH_DONE=1 for exactly one cycle, then the next state is RUN if FLUSH_REQ=0, else stay in DONE with FLUSH_DONE=0.
- Grants are allowed only in RUN.
- Grant condition: RUN, CREDIT_CNT>0, table entry at next_sbid is not valid, and at least one REQ_VALID is set.
- Arbitration is round-robin. The search starts at (last+1) mod NREQ. On reset last=NREQ-1, so requester 0 wins first. last updates only on a grant.
- On grant, at the edge:
  - credits decrement.
  - The table entry at next_sbid is set to valid, with owner set to the winning requester index.
  - next_sbid increments, wrapping mod 2^SBID_W.
  - The issue registers load the winner's instruction and the allocated sb_id.
- If next_sbid is still in flight, all granting stalls. sb_ids are allocated strictly in order with no skipping.
- Credits:
  - ISSUE_CREDIT increments the count.
  - A grant and a credit in the same cycle leave the count unchanged.
  - An increment that would exceed CREDITS is dropped and sets ERR.
- Completion: when COMPL_VALID=1, the table is read at COMPL_SBID.
  - Entry valid: set COMPL_ROUTE[owner] and clear the entry.
  - Entry invalid: COMPL_ROUTE stays 0 and ERR is set.
- Completion and allocation of the same sb_id in one cycle: the grant sees the pre-clear table and stalls, so the allocation happens one cycle later.
- In-flight count = number of valid table entries, held as a counter: +1 on grant, -1 on a valid completion, unchanged when both occur.
- Reset mid-operation clears the table, in-flight count, next_sbid, last, the issue registers and ERR, and restores credits to CREDITS. Completions in flight at reset are lost; this is the system's responsibility.

## Timing
- REQ_GRANT is combinational from the registered state and REQ_VALID, in the same cycle N.
- ISSUE_VALID, ISSUE_INSTR and ISSUE_SBID are registered and valid in cycle N+1 for one cycle.
- Sustained throughput is 1 issue/cycle while credits last.
- COMPL_ROUTE is registered, one cycle after COMPL_VALID, and is a one-cycle pulse.
- CREDIT_CNT is registered and reflects edge updates.
- Output values during and after reset:
  - REQ_GRANT=0, ISSUE_VALID=0, ISSUE_INSTR=0, ISSUE_SBID=0.
  - COMPL_ROUTE=0, FLUSH_DONE=0, ERR=0.
  - CREDIT_CNT=CREDITS.
- A FLUSH_REQ asserted in the same cycle as a grant candidate blocks that grant.

## Test plan
- Round-robin: NREQ=2, both REQ_VALID held, ISSUE_CREDIT returned every cycle. Expect grants 0,1,0,1 and ISSUE_SBID 0,1,2,3, each one cycle after its grant.
- Credit exhaustion: CREDITS=4, no ISSUE_CREDIT. Expect 4 grants, then CREDIT_CNT=0 and no grant. One ISSUE_CREDIT pulse produces exactly one further grant.
- Completion routing: requester 1 issues sb_id 0 and requester 0 issues sb_id 1. COMPL_VALID on sb_id 1 then sb_id 0 yields COMPL_ROUTE=01 then 10, each one cycle after its COMPL_VALID.
- sb_id wrap and stall: SBID_W=2 with ample credits; issue sb_ids 0..3 without completing. Expect no further grant. Completing sb_id 0 allows the next grant, which receives sb_id 0.
- Flush: 3 instructions in flight, FLUSH_REQ=1 with REQ_VALID=1. Expect no grants; FLUSH_DONE pulses once, the cycle after the last completion is absorbed. Grants resume after FLUSH_REQ drops.
- Errors: a completion on an unallocated sb_id, or an ISSUE_CREDIT at CREDIT_CNT=CREDITS, sets ERR=1 and leaves the count unchanged. ERR stays set until RST_N is pulled low mid-stream, after which all outputs return to their reset values.

Source files
------------

// File: rtl/ovi_issue_arbiter_if.sv
// rtl/ovi_issue_arbiter_if.sv - signal bundle between requesters, VPU side and the OVI issue arbiter
//
// Purpose: groups the requester issue buses, the VPU issue/credit/completion
// signals and the flush handshake into one bundle.
//   slave  modport: used by ovi_issue_arbiter
//   master modport: used by the environment (requesters + VPU model)
// Signals:
//   REQ_VALID[NREQ], REQ_INSTR[NREQ*32]  requester instructions
//   REQ_GRANT[NREQ]                      one-hot accept
//   ISSUE_VALID, ISSUE_INSTR, ISSUE_SBID registered issue toward the VPU
//   ISSUE_CREDIT                         credit return from the VPU
//   COMPL_VALID, COMPL_SBID              VPU completion
//   COMPL_ROUTE[NREQ]                    completion routed to its owner
//   FLUSH_REQ, FLUSH_DONE                drain handshake
//   CREDIT_CNT, ERR                      status
interface ovi_issue_arbiter_if #(
    parameter int NREQ   = 2,
    parameter int SBID_W = 5,
    parameter int CNT_W  = 3
);
    logic [NREQ-1:0]    REQ_VALID;
    logic [NREQ*32-1:0] REQ_INSTR;
    logic [NREQ-1:0]    REQ_GRANT;
    logic               ISSUE_VALID;
    logic [31:0]        ISSUE_INSTR;
    logic [SBID_W-1:0]  ISSUE_SBID;
    logic               ISSUE_CREDIT;
    logic               COMPL_VALID;
    logic [SBID_W-1:0]  COMPL_SBID;
    logic [NREQ-1:0]    COMPL_ROUTE;
    logic               FLUSH_REQ;
    logic               FLUSH_DONE;
    logic [CNT_W-1:0]   CREDIT_CNT;
    logic               ERR;

    modport slave (
        input  REQ_VALID, REQ_INSTR, ISSUE_CREDIT, COMPL_VALID, COMPL_SBID, FLUSH_REQ,
        output REQ_GRANT, ISSUE_VALID, ISSUE_INSTR, ISSUE_SBID, COMPL_ROUTE,
               FLUSH_DONE, CREDIT_CNT, ERR
    );

    modport master (
        output REQ_VALID, REQ_INSTR, ISSUE_CREDIT, COMPL_VALID, COMPL_SBID, FLUSH_REQ,
        input  REQ_GRANT, ISSUE_VALID, ISSUE_INSTR, ISSUE_SBID, COMPL_ROUTE,
               FLUSH_DONE, CREDIT_CNT, ERR
    );
endinterface

// File: rtl/ovi_issue_arbiter.sv
// rtl/ovi_issue_arbiter.sv - round-robin OVI issue arbiter with credits, sb_id ownership and flush
//
// Purpose: shares the single OVI issue port between NREQ requesters, tracks
// issue credits, allocates sb_ids in order, remembers which requester owns
// each in-flight sb_id and routes completions back to it. A flush request
// stops granting and waits until nothing is in flight.
// Ports:
//   CLK    clock, rising edge
//   RST_N  asynchronous active-low reset
//   bus    ovi_issue_arbiter_if.slave (requester, VPU and flush signals)
module ovi_issue_arbiter #(
    parameter int NREQ    = 2,
    parameter int CREDITS = 4,
    parameter int SBID_W  = 5
) (
    input  logic              CLK,
    input  logic              RST_N,
    ovi_issue_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(CREDITS + 1);
    localparam int LW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int DEPTH = 1 << SBID_W;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  credit_cnt;
    logic [DEPTH-1:0]  tbl_valid;
    logic [LW-1:0]     tbl_owner [DEPTH];
    logic [SBID_W:0]   inflight;
    logic [SBID_W-1:0] next_sbid;
    logic [LW-1:0]     last;
    logic              issue_valid;
    logic [31:0]       issue_instr;
    logic [SBID_W-1:0] issue_sbid;
    logic [NREQ-1:0]   compl_route;
    logic              flush_done;
    logic              err;

    logic [LW-1:0]     win;
    logic [LW-1:0]     idx;
    logic              any_req;
    logic              grant_ok;
    logic [NREQ-1:0]   req_grant;
    logic              compl_hit;
    logic              compl_bad;
    logic              credit_full;

    // Round-robin search starting one past the last winner.
    always_comb begin
        win     = '0;
        idx     = '0;
        any_req = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = LW'((int'(last) + 1 + k) % NREQ);
            if (!any_req && bus.REQ_VALID[idx]) begin
                win     = idx;
                any_req = 1'b1;
            end
        end
    end

    // The grant looks at the table before any same-cycle completion clears
    // it, so a completion of next_sbid delays its reallocation by one cycle.
    // RST_N is included so no grant is presented while reset is held.
    assign grant_ok = RST_N && (state == ST_RUN) && !bus.FLUSH_REQ &&
                      (credit_cnt != '0) && !tbl_valid[next_sbid] && any_req;

    always_comb begin
        req_grant = '0;
        if (grant_ok) begin
            req_grant[win] = 1'b1;
        end
    end

    assign compl_hit   = bus.COMPL_VALID && tbl_valid[bus.COMPL_SBID];
    assign compl_bad   = bus.COMPL_VALID && !tbl_valid[bus.COMPL_SBID];
    assign credit_full = (credit_cnt == CNT_W'(CREDITS));

    // Owner storage needs no reset: an entry is only read while its valid bit is set.
    always_ff @(posedge CLK) begin
        if (grant_ok) begin
            tbl_owner[next_sbid] <= win;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= ST_RUN;
            credit_cnt  <= CNT_W'(CREDITS);
            tbl_valid   <= '0;
            inflight    <= '0;
            next_sbid   <= '0;
            last        <= LW'(NREQ - 1);
            issue_valid <= 1'b0;
            issue_instr <= '0;
            issue_sbid  <= '0;
            compl_route <= '0;
            flush_done  <= 1'b0;
            err         <= 1'b0;
        end else begin
            issue_valid <= grant_ok;
            if (grant_ok) begin
                issue_instr          <= bus.REQ_INSTR[32*int'(win) +: 32];
                issue_sbid           <= next_sbid;
                next_sbid            <= next_sbid + SBID_W'(1);
                last                 <= win;
                tbl_valid[next_sbid] <= 1'b1;
            end

            // A grant only targets an invalid entry and a hit only clears a
            // valid one, so these two writes never touch the same bit.
            compl_route <= '0;
            if (compl_hit) begin
                tbl_valid[bus.COMPL_SBID]               <= 1'b0;
                compl_route[tbl_owner[bus.COMPL_SBID]] <= 1'b1;
            end

            if (grant_ok && !bus.ISSUE_CREDIT) begin
                credit_cnt <= credit_cnt - CNT_W'(1);
            end else if (!grant_ok && bus.ISSUE_CREDIT && !credit_full) begin
                credit_cnt <= credit_cnt + CNT_W'(1);
            end

            if (grant_ok && !compl_hit) begin
                inflight <= inflight + (SBID_W + 1)'(1);
            end else if (!grant_ok && compl_hit) begin
                inflight <= inflight - (SBID_W + 1)'(1);
            end

            if (compl_bad || (bus.ISSUE_CREDIT && !grant_ok && credit_full)) begin
                err <= 1'b1;
            end

            flush_done <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (bus.FLUSH_REQ) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if ((inflight == '0) && !issue_valid) begin
                        state      <= ST_DONE;
                        flush_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!bus.FLUSH_REQ) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    assign bus.REQ_GRANT   = req_grant;
    assign bus.ISSUE_VALID = issue_valid;
    assign bus.ISSUE_INSTR = issue_instr;
    assign bus.ISSUE_SBID  = issue_sbid;
    assign bus.COMPL_ROUTE = compl_route;
    assign bus.FLUSH_DONE  = flush_done;
    assign bus.CREDIT_CNT  = credit_cnt;
    assign bus.ERR         = err;
endmodule
